floor_scroller: RTL
===================

# floor_scroller

Parametrised platform generator for the side-scrolling play field. It holds `N_FLOORS` platform positions and scrolls them left by a programmable speed on each frame tick. A platform that leaves the left edge is recycled to the right end of the chain, with an LFSR-chosen height and optional gap insertion. Outputs feed the renderer and the player collision logic directly, in place of fixed per-platform coordinates.

## Interface
- `N_FLOORS`, 4: number of platforms, 2..8
- `COORD_W`, 11: coordinate width; `N_FLOORS*SPACING` must be < 2^`COORD_W`
- `X0`, 120: reset x of platform 0
- `SPACING`, 160: x pitch between consecutive platforms; must be > 15
- `Y_RESET`, 420: reset y of every platform
- `Y_MIN`, 300: lowest y value a recycled platform can take
- `Y_STEP`, 8: y quantum for recycled platforms
- `LFSR_SEED`, 16'hACE1: LFSR reset value, must be nonzero
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `tick`  in  1  frame strobe, one `clk` wide
- `pause`  in  1  1 = freeze all state (positions, LFSR, counter)
- `speed`  in  4  pixels moved per accepted tick, 0..15
- `gap_en`  in  1  1 = allow gaps at recycle
- `floor_x`  out  `N_FLOORS*COORD_W`  packed x, platform i at `[i*COORD_W +: COORD_W]`
- `floor_y`  out  `N_FLOORS*COORD_W`  packed y, same packing as `floor_x`
- `enable`  out  `N_FLOORS`  1 = platform i is solid and drawn
- `recycled`  out  `N_FLOORS`  one-cycle pulse: platform i wrapped on the last accepted tick
- `distance`  out  16  accumulated scroll distance, saturating

## Operation
- Reset values (asynchronous, while `rst`=0):
  - x_i = `X0` + i*`SPACING`
  - y_i = `Y_RESET`
  - `enable` = all ones
  - `recycled` = 0
  - `distance` = 0
  - LFSR = `LFSR_SEED`
  - internal `last_gap` = 0
- Accepted tick: `tick`=1 and `pause`=0. Nothing changes on any other cycle, except that `recycled` clears to 0.
- On an accepted tick, for each platform i:
  - If x_i >= `speed`: x_i <= x_i − `speed`, and `recycled[i]` <= 0.
  - Otherwise the platform wraps:
    - x_i <= x_i + `N_FLOORS*SPACING` − `speed`
    - y_i <= `Y_MIN` + L[3:0]*`Y_STEP`
    - `enable[i]` <= 0 if (`gap_en` & L[15] & ~`last_gap`), else 1
    - `last_gap` <= ~`enable[i]`_new
    - `recycled[i]` <= 1
  - L is the LFSR value before it steps on this tick.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It steps once per accepted tick, including when `speed`=0.
- Gap rule: two consecutive recycles never both produce gaps. With `gap_en`=0, every recycled platform has `enable`=1.
- At most one platform can wrap per tick, because `SPACING` > 15 >= `speed`. Recycle logic is shared, so there is one y/enable computation per tick.
- `distance` <= min(`distance` + `speed`, 16'hFFFF) on each accepted tick.
- `speed`=0: positions are unchanged, no wrap occurs, and the LFSR still steps.
- Reset asserted mid-operation returns all state to the reset values immediately, with no partial update.

## Timing
- All outputs are registered. A tick sampled at edge k is visible on the outputs after edge k; latency is one cycle.
- `recycled` stays high for exactly the cycle after the accepted tick.
- `tick` held high for several cycles is accepted once per cycle. The block performs no edge detection; the upstream logic guarantees a one-cycle strobe.
- `pause` and `tick` high together: the tick is ignored and is not deferred.
- Reset release is synchronous to `clk` upstream. The first tick can be accepted on the first edge after `rst` goes high.

## Test plan
- Reset check, with defaults: x = 120/280/440/600, y = 420 for all platforms, `enable`=4'b1111, `distance`=0, `recycled`=0.
- Plain scroll: `speed`=4, one tick -> x = 116/276/436/596, `distance`=4, y unchanged, `recycled`=0.
- Wrap: drive platform 0 to x=2, then tick with `speed`=4 -> x0=638, `recycled`=4'b0001 for one cycle, and y0 = 300 + L[3:0]*8 checked against a reference LFSR model.
- Gap rule: `gap_en`=1, force repeated recycles over 200 ticks at `speed`=15 -> no two consecutive recycled platforms both have `enable`=0. With `gap_en`=0 -> `enable` stays 4'b1111.
- Pause and `speed`=0:
  - `pause`=1 with 10 ticks -> every output and the LFSR are unchanged.
  - `speed`=0 with 10 ticks -> positions are unchanged and the LFSR has advanced 10 steps.
- Saturation and reset: drive `distance` near 16'hFFF8, then tick with `speed`=15 -> `distance`=16'hFFFF. Assert `rst`=0 mid-stream -> all outputs return to the reset values without waiting for a `clk` edge.

Source files
------------

// File: rtl/floor_scroller.sv
// Scrolling platform generator: shifts N platforms left per frame tick and recycles the
// one leaving the left edge to the right end with an LFSR-chosen height and optional gap.
module floor_scroller #(
  parameter int unsigned NFloors  = 4,
  parameter int unsigned CoordW   = 11,
  parameter int unsigned X0       = 120,
  parameter int unsigned Spacing  = 160,
  parameter int unsigned YReset   = 420,
  parameter int unsigned YMin     = 300,
  parameter int unsigned YStep    = 8,
  parameter logic [15:0] LfsrSeed = 16'hACE1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        tick_i,
  input  logic                        pause_i,
  input  logic [3:0]                  speed_i,
  input  logic                        gap_en_i,
  output logic [NFloors*CoordW-1:0]   floor_x_o,
  output logic [NFloors*CoordW-1:0]   floor_y_o,
  output logic [NFloors-1:0]          enable_o,
  output logic [NFloors-1:0]          recycled_o,
  output logic [15:0]                 distance_o
);

  typedef logic [CoordW-1:0] coord_t;

  localparam coord_t Span  = coord_t'(NFloors * Spacing);
  localparam coord_t YMinC = coord_t'(YMin);
  localparam coord_t YStpC = coord_t'(YStep);

  coord_t               x_q [NFloors];
  coord_t               x_d [NFloors];
  coord_t               y_q [NFloors];
  coord_t               y_d [NFloors];
  logic   [NFloors-1:0] en_q, en_d;
  logic   [NFloors-1:0] rec_q, rec_d;
  logic   [15:0]        dist_q, dist_d;
  logic   [15:0]        lfsr_q, lfsr_d;
  logic                 last_gap_q, last_gap_d;

  logic                 accept;
  logic                 gap;
  logic                 lfsr_fb;
  logic   [16:0]        dist_sum;
  coord_t               speed_c;
  coord_t               y_new;

  assign accept   = tick_i & ~pause_i;
  assign speed_c  = coord_t'(speed_i);
  // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1 on a left-shifting register.
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign gap      = gap_en_i & lfsr_q[15] & ~last_gap_q;
  assign y_new    = YMinC + coord_t'(lfsr_q[3:0]) * YStpC;
  assign dist_sum = {1'b0, dist_q} + {13'b0, speed_i};

  // Spacing > 15 guarantees at most one wrap per tick, so the shared y/gap result is safe.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    en_d       = en_q;
    rec_d      = '0;
    dist_d     = dist_q;
    lfsr_d     = lfsr_q;
    last_gap_d = last_gap_q;
    if (accept) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
      dist_d = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
      for (int i = 0; i < NFloors; i++) begin
        if (x_q[i] >= speed_c) begin
          x_d[i] = x_q[i] - speed_c;
        end else begin
          x_d[i]     = x_q[i] + Span - speed_c;
          y_d[i]     = y_new;
          en_d[i]    = ~gap;
          last_gap_d = gap;
          rec_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NFloors; i++) begin
        x_q[i] <= coord_t'(X0 + i * Spacing);
        y_q[i] <= coord_t'(YReset);
      end
      en_q       <= '1;
      rec_q      <= '0;
      dist_q     <= '0;
      lfsr_q     <= LfsrSeed;
      last_gap_q <= 1'b0;
    end else begin
      for (int i = 0; i < NFloors; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      en_q       <= en_d;
      rec_q      <= rec_d;
      dist_q     <= dist_d;
      lfsr_q     <= lfsr_d;
      last_gap_q <= last_gap_d;
    end
  end

  for (genvar g = 0; g < NFloors; g++) begin : g_pack
    assign floor_x_o[g*CoordW +: CoordW] = x_q[g];
    assign floor_y_o[g*CoordW +: CoordW] = y_q[g];
  end

  assign enable_o   = en_q;
  assign recycled_o = rec_q;
  assign distance_o = dist_q;

endmodule
